three_shuffler_ctrl: RTL and testbench

- Sequencer for the three-lane radix-3^2 shuffler datapath.
- Tracks sample position within a frame from a valid/start-of-frame stream.
- Generates the seven registered lane-switch selects (sel, sel1, sel2, sel4, sel5, sel6, sel7).
- Provides the output-side valid/start-of-frame aligned to the datapath latency, so downstream butterflies know when shuffled data is meaningful.

---
 rtl/three_shuffler_ctrl.sv | 149 ++++++++++++++
 tb/tb_three_shuffler_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/three_shuffler_ctrl.sv
// Sequencer for the three-lane radix-3^2 shuffler: tracks frame position, drives the
// registered lane-switch selects and re-times valid/start-of-frame to the datapath output.
module three_shuffler_ctrl #(
   parameter int FRAME_LEN = 81,
   parameter int PIPE_LAT  = 180,
   parameter int CW        = $clog2(FRAME_LEN)
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_sof,
   output logic sel,
   output logic sel1,
   output logic sel2,
   output logic sel4,
   output logic sel5,
   output logic sel6,
   output logic sel7,
   output logic out_valid,
   output logic out_sof,
   output logic busy,
   output logic frame_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] idx, idx_nxt;
   logic [1:0]    s_cnt, s_nxt;
   logic [1:0]    t_cnt, t_nxt;
   logic          blk, blk_nxt;

   logic          accept_p0;
   logic [CW-1:0] idx_p0;
   logic [1:0]    s_p0;
   logic [1:0]    t_p0;
   logic          blk_p0;

   logic [6:0]    sel_p1, sel_nxt;
   logic          err_p1, err_nxt;

   logic [PIPE_LAT-1:0] vld_dly;
   logic [PIPE_LAT-1:0] sof_dly;

   // Select bit order: {sel7, sel6, sel5, sel4, sel2, sel1, sel}
   function automatic logic [6:0] decode_sel(input logic [1:0] s_pos,
                                             input logic [1:0] t_pos,
                                             input logic       blk_odd);
      return {blk_odd, s_pos == 2'd2, s_pos == 2'd1,
              t_pos == 2'd2, t_pos == 2'd1, s_pos != 2'd0, t_pos == 2'd0};
   endfunction

   // Stage p0: position of the triple being accepted this cycle
   always_comb begin
      accept_p0 = in_valid & (in_sof | (state == RUN));
      idx_p0    = in_sof ? '0    : idx;
      s_p0      = in_sof ? 2'd0  : s_cnt;
      t_p0      = in_sof ? 2'd0  : t_cnt;
      blk_p0    = in_sof ? 1'b0  : blk;
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      s_nxt     = s_cnt;
      t_nxt     = t_cnt;
      blk_nxt   = blk;
      sel_nxt   = (state == RUN) ? sel_p1 : '0;
      err_nxt   = in_valid & in_sof & (state == RUN);

      if (accept_p0) begin
         sel_nxt = decode_sel(s_p0, t_p0, blk_p0);
         if (idx_p0 == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            s_nxt     = 2'd0;
            t_nxt     = 2'd0;
            blk_nxt   = 1'b0;
         end else begin
            state_nxt = RUN;
            idx_nxt   = idx_p0 + CW'(1);
            s_nxt     = (s_p0 == 2'd2) ? 2'd0 : s_p0 + 2'd1;
            t_nxt     = t_p0;
            blk_nxt   = blk_p0;
            // s wraps into t, t wraps into the 9-sample block parity
            if (s_p0 == 2'd2) begin
               t_nxt = (t_p0 == 2'd2) ? 2'd0 : t_p0 + 2'd1;
               if (t_p0 == 2'd2) begin
                  blk_nxt = ~blk_p0;
               end
            end
         end
      end
   end

   // Stage p1: registered control and selects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         idx    <= '0;
         s_cnt  <= 2'd0;
         t_cnt  <= 2'd0;
         blk    <= 1'b0;
         sel_p1 <= '0;
         err_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         s_cnt  <= s_nxt;
         t_cnt  <= t_nxt;
         blk    <= blk_nxt;
         sel_p1 <= sel_nxt;
         err_p1 <= err_nxt;
      end
   end

   // Output alignment: valid/sof delay line matching the datapath latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_dly <= '0;
         sof_dly <= '0;
      end else begin
         vld_dly[0] <= accept_p0;
         sof_dly[0] <= accept_p0 & (idx_p0 == '0);
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_dly[i] <= vld_dly[i-1];
            sof_dly[i] <= sof_dly[i-1];
         end
      end
   end

   assign sel       = sel_p1[0];
   assign sel1      = sel_p1[1];
   assign sel2      = sel_p1[2];
   assign sel4      = sel_p1[3];
   assign sel5      = sel_p1[4];
   assign sel6      = sel_p1[5];
   assign sel7      = sel_p1[6];
   assign frame_err = err_p1;
   assign out_valid = vld_dly[PIPE_LAT-1];
   assign out_sof   = sof_dly[PIPE_LAT-1];
   assign busy      = (state == RUN) | (|vld_dly);

endmodule

// File: tb/tb_three_shuffler_ctrl.sv
// Scoreboard bench for three_shuffler_ctrl: a frame-position model predicts selects,
// frame_err, busy and the delayed valid/sof stream; a monitor compares every cycle.
module tb_three_shuffler_ctrl;

   localparam int FRAME_LEN = 81;
   localparam int PIPE_LAT  = 180;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic in_sof = 1'b0;
   logic sel, sel1, sel2, sel4, sel5, sel6, sel7;
   logic out_valid, out_sof, busy, frame_err;

   three_shuffler_ctrl #(.FRAME_LEN(FRAME_LEN), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .sel(sel), .sel1(sel1), .sel2(sel2), .sel4(sel4), .sel5(sel5),
      .sel6(sel6), .sel7(sel7), .out_valid(out_valid), .out_sof(out_sof),
      .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int unsigned due;
      logic        sof;
   } out_ent_t;

   typedef struct packed {
      logic [6:0] sels;
      logic       err;
      logic       busy;
   } cyc_exp_t;

   out_ent_t    out_q[$];
   cyc_exp_t    cyc_q[$];
   int unsigned cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   logic [6:0]  sels_dut;
   logic [10:0] all_out;
   assign sels_dut = {sel7, sel6, sel5, sel4, sel2, sel1, sel};
   assign all_out  = {sels_dut, out_valid, out_sof, busy, frame_err};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: frame position as a plain integer, selects by arithmetic
   int   m_idx = 0;
   bit   m_run = 1'b0;
   logic [6:0] m_sels = '0;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_idx  = 0;
            m_run  = 1'b0;
            m_sels = '0;
            out_q.delete();
            cyc_q.delete();
         end else begin
            cyc_exp_t e;
            int k, s, t, b;
            cyc++;
            e.err = 1'b0;
            if (in_valid && (m_run || in_sof)) begin
               k = in_sof ? 0 : m_idx;
               e.err = in_sof && m_run;
               s = k % 3;
               t = (k / 3) % 3;
               b = (k / 9) % 2;
               m_sels = {b == 1, s == 2, s == 1, t == 2, t == 1, s != 0, t == 0};
               out_q.push_back('{due: cyc + PIPE_LAT - 1, sof: (k == 0)});
               if (k == FRAME_LEN - 1) begin
                  m_run = 1'b0;
                  m_idx = 0;
               end else begin
                  m_run = 1'b1;
                  m_idx = k + 1;
               end
            end else if (!m_run) begin
               m_sels = '0;
            end
            e.sels = m_sels;
            e.busy = m_run || (out_q.size() > 0);
            cyc_q.push_back(e);
         end
      end
   end

   // Monitor: compare on the falling edge, away from DUT updates
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("reset_outputs", 32'(all_out), 32'd0);
         end else begin
            cyc_exp_t e;
            logic exp_v, exp_s;
            e = '0;
            if (cyc_q.size() > 0) e = cyc_q.pop_front();
            check("selects", 32'(sels_dut), 32'(e.sels));
            check("frame_err", 32'(frame_err), 32'(e.err));
            check("busy", 32'(busy), 32'(e.busy));
            exp_v = 1'b0;
            exp_s = 1'b0;
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
               exp_v = 1'b1;
               exp_s = out_q[0].sof;
               void'(out_q.pop_front());
            end
            check("out_valid", 32'(out_valid), 32'(exp_v));
            check("out_sof", 32'(out_sof), 32'(exp_s));
         end
      end
   end

   task automatic drive(input logic v, input logic s);
      in_valid = v;
      in_sof   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'(all_out), 32'd0);
      rst = 1'b1;
      idle(2);

      // One full frame, then drain
      drive(1'b1, 1'b1);
      for (int i = 1; i < FRAME_LEN; i++) drive(1'b1, 1'b0);
      idle(PIPE_LAT + 10);

      // Two back-to-back frames
      for (int f = 0; f < 2; f++) begin
         drive(1'b1, 1'b1);
         for (int i = 1; i < FRAME_LEN; i++) drive(1'b1, 1'b0);
      end
      idle(PIPE_LAT + 10);

      // Alternating valid across a whole frame
      for (int i = 0; i < 2 * FRAME_LEN; i++) drive(i % 2 == 0, i == 0);
      idle(PIPE_LAT + 10);

      // Premature sof at idx 40, then a complete frame
      drive(1'b1, 1'b1);
      for (int i = 1; i < 40; i++) drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      for (int i = 1; i < FRAME_LEN; i++) drive(1'b1, 1'b0);
      idle(5);

      // Valid without sof in IDLE is ignored
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
      idle(PIPE_LAT + 10);

      // Asynchronous reset at idx 50 with samples in flight
      drive(1'b1, 1'b1);
      for (int i = 1; i < 50; i++) drive(1'b1, 1'b0);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 32'(all_out), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(PIPE_LAT + 20);

      // Randomized traffic with gaps and occasional resyncs
      for (int i = 0; i < 3000; i++) begin
         logic v, s;
         v = ($urandom % 4) != 0;
         s = ($urandom % 70) == 0;
         drive(v, s);
      end
      idle(PIPE_LAT + 10);
      check("drain_empty", 32'(out_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
